// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and instruction constants for the instruction sequencer
package seq_pkg;
    typedef enum logic [2:0] {BOOT, FETCH, EXEC, WB, HALT} seq_state_t;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam int unsigned PC_INC      = 4;
endpackage

// File: rtl/instr_sequencer_perf_counters.sv
// seq_perf_counters: free-running 64-bit cycle and retired-instruction counters
module seq_perf_counters
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  seq_state_t  i_state,
    output logic [63:0] o_cycle_count,
    output logic [63:0] o_instret_count
);
    logic [63:0] r_cyc;
    logic [63:0] r_ret;
    logic        w_cyc_en;
    logic        w_ret_en;

    assign w_cyc_en = (i_state != HALT) && (i_state != BOOT);
    assign w_ret_en = i_state == WB;

    // count active cycles and writeback cycles, wrapping silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc <= '0;
            r_ret <= '0;
        end else begin
            if (w_cyc_en) r_cyc <= r_cyc + 64'd1;
            if (w_ret_en) r_ret <= r_ret + 64'd1;
        end
    end

    assign o_cycle_count   = r_cyc;
    assign o_instret_count = r_ret;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/exec/writeback sequencer owning PC and IR.
// Optional perf counters are built when SEQ_PERF_COUNTERS_EN is defined.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned             PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                dec_regwrite,
    input  logic                dec_gpio_we,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                halt_req,
    input  logic                resume,
    output logic                regwrite_en,
    output logic                gpio_we_en,
    output logic                halted
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [63:0]         cycle_count,
    output logic [63:0]         instret_count
`endif
);
    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_instr;
    logic                w_in_wb;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= BOOT;
        else       r_state <= w_next;
    end

    // next-state: halt_req only matters in WB, resume only in HALT
    always_comb begin
        w_next = r_state;
        case (r_state)
            BOOT:    w_next = FETCH;
            FETCH:   w_next = imem_ready ? EXEC : FETCH;
            EXEC:    w_next = (r_instr == EBREAK_INSN) ? HALT : WB;
            WB:      w_next = halt_req ? HALT : FETCH;
            HALT:    w_next = resume ? FETCH : HALT;
            default: w_next = BOOT;
        endcase
    end

    // latch the fetched word on accept; advance or redirect the PC at writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSN;
        end else begin
            if (r_state == FETCH && imem_ready) r_instr <= imem_rdata;
            if (w_in_wb) r_pc <= branch_taken ? {branch_target[PC_WIDTH-1:2], 2'b00}
                                              : r_pc + PC_WIDTH'(PC_INC);
        end
    end

    assign w_in_wb     = r_state == WB;
    assign imem_req    = r_state == FETCH;
    assign imem_addr   = imem_req ? r_pc : '0;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign regwrite_en = w_in_wb & dec_regwrite;
    assign gpio_we_en  = w_in_wb & dec_gpio_we;
    assign halted      = r_state == HALT;

`ifdef SEQ_PERF_COUNTERS_EN
    seq_perf_counters u_perf (
        .clk             (clk),
        .reset           (reset),
        .i_state         (r_state),
        .o_cycle_count   (cycle_count),
        .o_instret_count (instret_count)
    );
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: instruction-level schedule model checked against the sequencer every cycle
module tb_instr_sequencer;
    localparam logic [31:0] RPC    = 32'h100;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready, dec_regwrite, dec_gpio_we, branch_taken;
    logic        halt_req, resume, regwrite_en, gpio_we_en, halted;
    logic [31:0] imem_addr, imem_rdata, instr, pc, branch_target;
`ifdef SEQ_PERF_COUNTERS_EN
    logic [63:0] cycle_count, instret_count;
`endif

    int tests = 0;
    int fails = 0;

    logic        chk = 1'b0;
    logic        e_req, e_rw, e_gw, e_halt;
    logic [31:0] e_addr, e_pc, e_instr;
    logic [63:0] e_cyc, e_ret;
    logic [31:0] m_pc, m_ir;
    logic [63:0] m_cyc, m_ret;

    instr_sequencer #(.PC_WIDTH(32), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .pc            (pc),
        .dec_regwrite  (dec_regwrite),
        .dec_gpio_we   (dec_gpio_we),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .regwrite_en   (regwrite_en),
        .gpio_we_en    (gpio_we_en),
        .halted        (halted)
`ifdef SEQ_PERF_COUNTERS_EN
        ,
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare every output against the schedule's expectations mid-cycle
    always @(negedge clk) begin
        if (chk) begin
            check("imem_req", {63'd0, imem_req}, {63'd0, e_req});
            if (e_req) check("imem_addr", {32'd0, imem_addr}, {32'd0, e_addr});
            check("pc", {32'd0, pc}, {32'd0, e_pc});
            check("instr", {32'd0, instr}, {32'd0, e_instr});
            check("regwrite_en", {63'd0, regwrite_en}, {63'd0, e_rw});
            check("gpio_we_en", {63'd0, gpio_we_en}, {63'd0, e_gw});
            check("halted", {63'd0, halted}, {63'd0, e_halt});
`ifdef SEQ_PERF_COUNTERS_EN
            check("cycle_count", cycle_count, e_cyc);
            check("instret_count", instret_count, e_ret);
`endif
        end
    end

    task automatic noise();
        dec_regwrite  = 1'($urandom);
        dec_gpio_we   = 1'($urandom);
        branch_taken  = 1'($urandom);
        branch_target = $urandom;
        halt_req      = 1'($urandom);
        resume        = 1'($urandom);
        imem_ready    = 1'($urandom);
        imem_rdata    = $urandom;
    endtask

    // one clock of the schedule: publish expectations, then advance past the edge
    task automatic step(input logic req, input logic wb, input logic hlt, input logic cnt);
        e_req   = req;
        e_addr  = m_pc;
        e_pc    = m_pc;
        e_instr = m_ir;
        e_rw    = wb & dec_regwrite;
        e_gw    = wb & dec_gpio_we;
        e_halt  = hlt;
        e_cyc   = m_cyc;
        e_ret   = m_ret;
        chk     = 1'b1;
        @(posedge clk);
        #1;
        if (cnt) m_cyc++;
        if (wb)  m_ret++;
    endtask

    task automatic halt_wait(input int dly);
        for (int i = 0; i <= dly; i++) begin
            noise();
            resume = (i == dly);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic run_insn(input logic [31:0] w, input int waits, input logic rw, input logic gw,
                            input logic br, input logic [31:0] tgt, input logic hreq, input int hdly);
        for (int i = 0; i <= waits; i++) begin
            noise();
            imem_ready = (i == waits);
            if (i == waits) imem_rdata = w;
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        m_ir = w;
        noise();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        if (w == EBREAK) halt_wait(hdly);
        else begin
            noise();
            dec_regwrite  = rw;
            dec_gpio_we   = gw;
            branch_taken  = br;
            branch_target = tgt;
            halt_req      = hreq;
            step(1'b0, 1'b1, 1'b0, 1'b1);
            m_pc = br ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
            if (hreq) halt_wait(hdly);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_pc  = RPC;
        m_ir  = NOP;
        m_cyc = '0;
        m_ret = '0;
        noise();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        noise();
        #1;
        do_reset();
        for (int k = 0; k < 3; k++) run_insn(NOP, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 0);
        check("pin_seq_addr", {32'd0, imem_addr}, 64'h10C);
`ifdef SEQ_PERF_COUNTERS_EN
        check("pin_cycles", cycle_count, 64'd9);
        check("pin_instret", instret_count, 64'd3);
`endif
        run_insn(32'h0000_0033, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b0, 0);
        check("pin_branch_addr", {32'd0, imem_addr}, 64'h200);
        run_insn(32'h0000_0033, 1, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 0);
        run_insn(32'h0000_00B3, 4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 0);
        check("pin_wait_instr", {32'd0, instr}, 64'h0000_00B3);
        run_insn(32'h0010_1073, 0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
        check("pin_top_addr", {32'd0, imem_addr}, 64'hFFFF_FFFC);
        run_insn(NOP, 2, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        check("pin_wrap_addr", {32'd0, imem_addr}, 64'h0);
        run_insn(EBREAK, 0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 3);
        check("pin_refetch_addr", {32'd0, imem_addr}, 64'h0);
        check("pin_refetch_req", {63'd0, imem_req}, 64'd1);
        run_insn(NOP, 0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 2);
        check("pin_halt_pc", {32'd0, pc}, 64'h4);
        for (int k = 0; k < 300; k++) begin
            logic [31:0] w;
            w = ($urandom_range(7) == 0) ? EBREAK : $urandom;
            run_insn(w, $urandom_range(3), 1'($urandom), 1'($urandom),
                     $urandom_range(3) == 0, $urandom, $urandom_range(7) == 0, $urandom_range(3));
        end
        noise();
        imem_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        check("pin_reset_pc", {32'd0, pc}, 64'h100);
        run_insn(32'h0000_0133, 1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 0);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
